lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller for the memory/writeback stage of the three-stage pipeline. It takes the stage's memory-access control (read/write, funct3, address, store data) and runs a request/acknowledge transaction to data memory. It aligns and extends load data and produces the one-cycle `loaded` pulse that releases the hazard unit's load-use stall. It also drives `busy`, which the top level ORs into the global stall so the memory instruction stays frozen in its stage until the access completes.

## Interface
- `TIMEOUT_CYCLES`, 255, max cycles to wait for `dmem_ack` before aborting with `bus_err`
- `clk`  in  1  clock; everything is rising-edge
- `rst_n`  in  1  asynchronous, active-low reset
- `mem_read`  in  1  stage instruction is a load
- `mem_write`  in  1  stage instruction is a store
- `funct3`  in  3  [1:0] size (00 byte, 01 half, 1x word); [2] unsigned load
- `addr`  in  32  effective byte address
- `wdata`  in  32  store data (rs2)
- `dmem_req`  out  1  request valid, registered
- `dmem_we`  out  1  write request, registered
- `dmem_addr`  out  32  word address {addr[31:2],2'b00}, registered
- `dmem_be`  out  4  byte enables, registered
- `dmem_wdata`  out  32  lane-replicated store data, registered
- `dmem_ack`  in  1  memory completes the current request
- `dmem_rdata`  in  32  read word, valid with `dmem_ack`
- `rdata`  out  32  aligned/extended load result, registered
- `loaded`  out  1  one-cycle pulse: `rdata` is valid for the current load
- `busy`  out  1  access pending; the stage must hold
- `misaligned`  out  1  combinational access fault; no memory access is made
- `bus_err`  out  1  one-cycle pulse on timeout

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - An op (`mem_read|mem_write`) that is aligned registers the request outputs, `dmem_req`=1, and goes to REQ.
  - If both reads and writes are asserted, the read wins.
- Misaligned op: half with addr[0]=1, or word with addr[1:0]≠0.
  - `misaligned`=1, `busy`=0, no request, stay in IDLE, `rdata` unchanged.
- REQ:
  - Request outputs are held stable.
  - On `dmem_ack`: a load captures the extended data into `rdata`, drops `dmem_req`, and goes to DONE; a store drops `dmem_req` and goes to IDLE.
- DONE: `loaded`=1 for exactly one cycle, then IDLE.
- Watchdog:
  - The counter clears on entry to REQ and increments each REQ cycle without ack.
  - At TIMEOUT_CYCLES it drops `dmem_req` and pulses `bus_err`.
  - A load goes to DONE with `rdata`=0; a store goes to IDLE.
- `busy` = (IDLE & op & ~misaligned) | REQ. It is combinational so the instruction is held from its first cycle. It is 0 in DONE.
- Byte enables:
  - byte: 0001<<addr[1:0]
  - half: 0011<<{addr[1],1'b0}
  - word: 1111
  - The same enables are driven for loads.
- Store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
- Load extract: lane = dmem_rdata>>(8*addr[1:0]). Sign-extend when funct3[2]=0, zero-extend when it is 1. A word is passed through.

## Timing
- Reset values: all outputs 0; state IDLE; counter 0. Reset mid-transaction drops `dmem_req` immediately and discards the access.
- Load, zero-wait memory:
  - cycle 0: op seen, `busy`=1
  - cycle 1: `dmem_req`=1, ack
  - cycle 2: DONE, `loaded`=1, `rdata` valid
  - The pipeline advances at the end of cycle 2. Load latency is 3 cycles plus memory wait states.
- Store, zero-wait memory: cycle 0 op seen, cycle 1 req+ack, IDLE at cycle 2. Store latency is 2 cycles plus wait states.
- A new op can be accepted in the first IDLE cycle after DONE or after a store ack. This gives back-to-back loads every 3 cycles.
- `dmem_ack` outside REQ is ignored.
- Ack in the same cycle as the watchdog expiry is treated as a normal completion.
- `rdata` holds its value until the next load completion.

## Structure
- `lsu_pkg` holds:
  - the state enum (IDLE/REQ/DONE)
  - size encodings (SZ_B=2'b00, SZ_H=2'b01, SZ_W=2'b10)
  - the default TIMEOUT_CYCLES
- Sub-module `lsu_align` is purely combinational: byte enables, store replication, load extract/extend, and misalignment detection. It is instantiated once.

## Test plan
- LW addr=0x100, ack in the first REQ cycle, rdata=0xDEADBEEF -> `dmem_addr`=0x100, be=1111; `loaded` at cycle 2; `rdata`=0xDEADBEEF.
- LB addr=0x103, word 0x80112233 -> be=1000, `rdata`=0xFFFFFF80; the same word with LBU -> 0x00000080.
- SH addr=0x22, wdata=0x0000ABCD, ack after 3 wait states -> be=1100, `dmem_wdata`=0xABCDABCD; `busy` high 5 cycles; `loaded` never asserts.
- LW addr=0x102 -> `misaligned`=1, `busy`=0, `dmem_req` stays 0, `rdata` unchanged.
- LW with no ack, TIMEOUT_CYCLES=4 -> `dmem_req` high 4 cycles, then `bus_err` and `loaded` pulse together; `rdata`=0.
- `rst_n` low while in REQ -> `dmem_req`, `busy` and `rdata` go to 0 asynchronously; after release, a new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store controller
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - data memory request/acknowledge bus
interface lsu_ctrl_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store lane replication, load extract and misalignment
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_ext,
    output logic        mis
);

    logic [31:0] lane;
    logic        sext;

    assign lane = rdata_word >> {addr_lo, 3'b000};
    assign sext = ~funct3[2];

    // Size decode: size 2'b11 is treated as a word like 2'b10
    always_comb begin
        be        = 4'b1111;
        wdata_rep = wdata;
        load_ext  = rdata_word;
        mis       = 1'b0;
        case (funct3[1:0])
            SZ_B: begin
                be        = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
                load_ext  = {{24{sext & lane[7]}}, lane[7:0]};
            end
            SZ_H: begin
                be        = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                load_ext  = {{16{sext & lane[15]}}, lane[15:0]};
                mis       = addr_lo[0];
            end
            default: begin
                mis = |addr_lo;
            end
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store controller for the memory/writeback stage
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    lsu_ctrl_if.master        dmem,
    output logic [31:0]       rdata,
    output logic              loaded,
    output logic              busy,
    output logic              misaligned,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q, state_d;
    logic             req_q, req_d;
    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [3:0]       be_q, be_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic             op;
    logic             mis;
    logic [3:0]       be_c;
    logic [31:0]      wdata_c;
    logic [31:0]      load_c;

    lsu_align u_align (
        .funct3     (funct3),
        .addr_lo    (addr[1:0]),
        .wdata      (wdata),
        .rdata_word (dmem.dmem_rdata),
        .be         (be_c),
        .wdata_rep  (wdata_c),
        .load_ext   (load_c),
        .mis        (mis)
    );

    assign op         = mem_read | mem_write;
    assign misaligned = op & mis;
    // Combinational so the stage freezes in the op's first cycle; reset releases it at once
    assign busy       = rst_n & (((state_q == IDLE) & op & ~mis) | (state_q == REQ));
    assign loaded     = (state_q == DONE);
    assign bus_err    = err_q;
    assign rdata      = rdata_q;

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

    // Next-state: issue in IDLE, complete or time out in REQ, one-cycle DONE pulse
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (op && !mis) begin
                    req_d   = 1'b1;
                    we_d    = mem_write & ~mem_read;
                    addr_d  = {addr[31:2], 2'b00};
                    be_d    = be_c;
                    wdata_d = wdata_c;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dmem.dmem_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = load_c;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    req_d = 1'b0;
                    err_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = '0;
                        state_d = DONE;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and request registers; reset abandons any access in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - scoreboard bench for lsu_ctrl
module tb_lsu_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        loaded;
    logic        busy;
    logic        misaligned;
    logic        bus_err;

    lsu_ctrl_if dif ();

    lsu_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .dmem       (dif.master),
        .rdata      (rdata),
        .loaded     (loaded),
        .busy       (busy),
        .misaligned (misaligned),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } ld_t;

    req_t req_sb[$];
    ld_t  ld_sb[$];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] mem_word = 32'h0;
    int          mem_wait = 0;
    int          wcnt = 0;
    logic        stray_ack = 1'b0;
    logic        req_prev = 1'b0;
    logic [31:0] last_rd = 32'h0;
    req_t        mr;
    ld_t         ml;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: ack after mem_wait REQ cycles; optional stray ack while idle
    always @(negedge clk) begin
        if (dif.dmem_req) begin
            dif.dmem_ack   = (wcnt == mem_wait);
            dif.dmem_rdata = (wcnt == mem_wait) ? mem_word : 32'hBAD0BAD0;
            wcnt++;
        end else begin
            wcnt = 0;
            dif.dmem_ack   = stray_ack;
            dif.dmem_rdata = 32'h5555AAAA;
        end
    end

    // Monitor: compare each new request and each loaded pulse against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            if (dif.dmem_req && !req_prev) begin
                if (req_sb.size() == 0) begin
                    check("unexpected_req", {31'h0, dif.dmem_req}, 32'h0);
                end else begin
                    mr = req_sb.pop_front();
                    check("req_we", {31'h0, dif.dmem_we}, {31'h0, mr.we});
                    check("req_addr", dif.dmem_addr, mr.addr);
                    check("req_be", {28'h0, dif.dmem_be}, {28'h0, mr.be});
                    if (mr.we) check("req_wdata", dif.dmem_wdata, mr.wdata);
                end
            end
            if (loaded) begin
                if (ld_sb.size() == 0) begin
                    check("unexpected_loaded", {31'h0, loaded}, 32'h0);
                end else begin
                    ml = ld_sb.pop_front();
                    check("load_rdata", rdata, ml.rdata);
                    check("load_bus_err", {31'h0, bus_err}, {31'h0, ml.err});
                    check("load_cycle", cyc, ml.cyc);
                end
            end else if (bus_err) begin
                check("unexpected_bus_err", {31'h0, bus_err}, 32'h0);
            end
        end
        req_prev = dif.dmem_req;
    end

    task automatic run_op(input string nm, input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] word,
                          input int waits, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                          input logic [31:0] exp_rd, input logic exp_err);
        int busy_n = 0;
        int req_n = 0;
        int start;
        bit seen = 0;
        bit done = 0;
        @(posedge clk); #1;
        mem_read  = rd;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        mem_word  = word;
        mem_wait  = waits;
        start     = cyc;
        req_sb.push_back('{we: wr & ~rd, addr: {a[31:2], 2'b00}, be: exp_be, wdata: exp_wd});
        if (rd) begin
            ld_sb.push_back('{rdata: exp_rd, err: exp_err,
                              cyc: start + (exp_err ? TO : waits + 1) + 1});
            last_rd = exp_rd;
        end
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge clk); #1;
            if (busy) busy_n++;
            if (dif.dmem_req) begin
                req_n++;
                seen = 1;
                if (dif.dmem_ack) done = 1;
            end else if (seen) begin
                done = 1;
            end
        end
        check({nm, "_completed"}, {31'h0, done}, 32'h1);
        @(posedge clk); #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check({nm, "_busy_cycles"}, 32'(busy_n), 32'(exp_err ? TO + 1 : waits + 2));
        check({nm, "_req_cycles"}, 32'(req_n), 32'(exp_err ? TO : waits + 1));
    endtask

    task automatic run_mis(input string nm, input logic [2:0] f3, input logic [31:0] a);
        @(posedge clk); #1;
        mem_read  = 1'b1;
        funct3    = f3;
        addr      = a;
        stray_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            check({nm, "_misaligned"}, {31'h0, misaligned}, 32'h1);
            check({nm, "_busy"}, {31'h0, busy}, 32'h0);
            check({nm, "_req"}, {31'h0, dif.dmem_req}, 32'h0);
            check({nm, "_rdata"}, rdata, last_rd);
        end
        @(posedge clk); #1;
        mem_read  = 1'b0;
        stray_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        dif.dmem_ack   = 1'b0;
        dif.dmem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req", {31'h0, dif.dmem_req}, 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_loaded", {31'h0, loaded}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_bus_err", {31'h0, bus_err}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_req", {31'h0, dif.dmem_req}, 32'h0);
        check("post_rst_misaligned", {31'h0, misaligned}, 32'h0);

        run_op("lw",   1, 0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 4'b1111, 32'h0,        32'hDEADBEEF, 0);
        run_op("lb",   1, 0, 3'b000, 32'h103, 32'h0,        32'h80112233, 0, 4'b1000, 32'h0,        32'hFFFFFF80, 0);
        run_op("lbu",  1, 0, 3'b100, 32'h103, 32'h0,        32'h80112233, 0, 4'b1000, 32'h0,        32'h00000080, 0);
        run_op("sh",   0, 1, 3'b001, 32'h22,  32'h0000ABCD, 32'h0,        3, 4'b1100, 32'hABCDABCD, 32'h0,        0);
        run_mis("lw_mis", 3'b010, 32'h102);
        run_op("lw_to", 1, 0, 3'b010, 32'h104, 32'h0,       32'h0,        1000, 4'b1111, 32'h0,     32'h0,        1);
        run_op("sb",   0, 1, 3'b000, 32'h101, 32'h1234565A, 32'h0,        1, 4'b0010, 32'h5A5A5A5A, 32'h0,        0);
        run_op("rdwr", 1, 1, 3'b010, 32'h40,  32'h11111111, 32'hCAFEF00D, 0, 4'b1111, 32'h0,        32'hCAFEF00D, 0);
        run_op("lh",   1, 0, 3'b001, 32'h102, 32'h0,        32'h80011234, 2, 4'b1100, 32'h0,        32'hFFFF8001, 0);

        @(posedge clk); #1;
        mem_read  = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h300;
        mem_wait  = 1000;
        req_sb.push_back('{we: 1'b0, addr: 32'h300, be: 4'b1111, wdata: 32'h0});
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_req", {31'h0, dif.dmem_req}, 32'h0);
        check("midrst_busy", {31'h0, busy}, 32'h0);
        check("midrst_rdata", rdata, 32'h0);
        mem_read = 1'b0;
        last_rd  = 32'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("lw_after_rst", 1, 0, 3'b010, 32'h200, 32'h0, 32'h12345678, 0, 4'b1111, 32'h0, 32'h12345678, 0);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("req_sb_drained", 32'(req_sb.size()), 32'h0);
        check("ld_sb_drained", 32'(ld_sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
